// File: rtl/systolic_skew_feeder_if.sv
// Operand beat stream (A column + B row per k-step) between an operand source and the skew feeder.
interface systolic_skew_feeder_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic           op_valid;
  logic           op_ready;
  logic [N*W-1:0] op_a;
  logic [N*W-1:0] op_b;

  modport master (
    output op_valid,
    output op_a,
    output op_b,
    input  op_ready
  );

  modport slave (
    input  op_valid,
    input  op_a,
    input  op_b,
    output op_ready
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Skewing operand feeder for an NxN systolic MAC array: feed k_len beats, flush 2N-1 zero advances, drain N.
// Optional job abort (abort/aborted ports) is compiled in when SYSTOLIC_FEEDER_ABORT_EN is defined.
module systolic_skew_feeder #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int KW = 16
) (
  input  logic                   CLOCK,
  input  logic                   reset,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  output logic                   busy,
  output logic                   done,
  systolic_skew_feeder_if.slave  op,
  output logic [N*W-1:0]         arr_col,
  output logic [N*W-1:0]         arr_row,
  output logic                   arr_valid,
  output logic                   arr_mult_over,
  output logic                   arr_clear
`ifdef SYSTOLIC_FEEDER_ABORT_EN
  ,
  input  logic                   abort,
  output logic                   aborted
`endif
);

  localparam int CW = $clog2(3 * N);

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    FLUSH,
    DRAIN,
    DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [KW-1:0]   k_len_reg;
  logic [KW-1:0]   beat_cnt_reg, beat_cnt_next;
  logic [CW-1:0]   phase_cnt_reg, phase_cnt_next;

  logic            advance;
  logic            abort_hit;
  logic            clear_set;
  logic            done_set;

  logic            arr_valid_reg;
  logic            arr_mult_over_reg;
  logic            arr_clear_reg;
  logic            done_reg;

  logic [N*W-1:0]  feed_a;
  logic [N*W-1:0]  feed_b;

  // ---------------------------------------------------------------- FSM state
  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state_reg     <= IDLE;
      k_len_reg     <= '0;
      beat_cnt_reg  <= '0;
      phase_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      beat_cnt_reg  <= beat_cnt_next;
      phase_cnt_reg <= phase_cnt_next;
      if (state_reg == IDLE && start) begin
        k_len_reg <= k_len;
      end
    end
  end

  // ---------------------------------------------------------------- FSM next state
  always_comb begin
    state_next     = state_reg;
    beat_cnt_next  = beat_cnt_reg;
    phase_cnt_next = phase_cnt_reg;
    advance        = 1'b0;
    clear_set      = 1'b0;
    done_set       = 1'b0;
    abort_hit      = 1'b0;

`ifdef SYSTOLIC_FEEDER_ABORT_EN
    abort_hit = abort && (state_reg == FEED || state_reg == FLUSH || state_reg == DRAIN);
`endif

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (k_len != '0) begin
            state_next     = FEED;
            beat_cnt_next  = '0;
            phase_cnt_next = '0;
            clear_set      = 1'b1;
          end else begin
            done_set = 1'b1;
          end
        end
      end
      FEED: begin
        if (op.op_valid) begin
          advance = 1'b1;
          if (beat_cnt_reg == k_len_reg - KW'(1)) begin
            state_next     = FLUSH;
            phase_cnt_next = '0;
          end else begin
            beat_cnt_next = beat_cnt_reg + KW'(1);
          end
        end
      end
      // Zeros push the last beat through the skew tail, the array hops and the MAC register.
      FLUSH: begin
        advance = 1'b1;
        if (phase_cnt_reg == CW'(2 * N - 2)) begin
          state_next     = DRAIN;
          phase_cnt_next = '0;
        end else begin
          phase_cnt_next = phase_cnt_reg + CW'(1);
        end
      end
      DRAIN: begin
        advance = 1'b1;
        if (phase_cnt_reg == CW'(N - 1)) begin
          state_next     = DONE;
          phase_cnt_next = '0;
          done_set       = 1'b1;
        end else begin
          phase_cnt_next = phase_cnt_reg + CW'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Abort takes priority over any accept or count step on the same edge.
    if (abort_hit) begin
      state_next     = IDLE;
      beat_cnt_next  = '0;
      phase_cnt_next = '0;
      advance        = 1'b0;
      done_set       = 1'b0;
      clear_set      = 1'b1;
    end
  end

  // ---------------------------------------------------------------- control outputs
  always_ff @(posedge CLOCK) begin
    if (reset) begin
      arr_valid_reg     <= 1'b0;
      arr_mult_over_reg <= 1'b0;
      arr_clear_reg     <= 1'b0;
      done_reg          <= 1'b0;
    end else begin
      arr_clear_reg <= clear_set;
      done_reg      <= done_set;
      if (abort_hit) begin
        arr_valid_reg     <= 1'b0;
        arr_mult_over_reg <= 1'b0;
      end else if (advance) begin
        arr_valid_reg     <= 1'b1;
        arr_mult_over_reg <= (state_reg == DRAIN);
      end else begin
        arr_valid_reg <= 1'b0;
        if (state_reg == DONE) begin
          arr_mult_over_reg <= 1'b0;
        end
      end
    end
  end

`ifdef SYSTOLIC_FEEDER_ABORT_EN
  logic aborted_reg;

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      aborted_reg <= 1'b0;
    end else begin
      aborted_reg <= abort_hit;
    end
  end

  assign aborted = aborted_reg;
`endif

  assign busy          = (state_reg != IDLE);
  assign done          = done_reg;
  assign op.op_ready   = (state_reg == FEED);
  assign arr_valid     = arr_valid_reg;
  assign arr_mult_over = arr_mult_over_reg;
  assign arr_clear     = arr_clear_reg;

  // Outside FEED the advances shift zeros into the skew chains.
  assign feed_a = (state_reg == FEED) ? op.op_a : '0;
  assign feed_b = (state_reg == FEED) ? op.op_b : '0;

  // ---------------------------------------------------------------- per-lane skew
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [W-1:0] a_in;
      logic [W-1:0] b_in;
      logic [W-1:0] col_lane_reg;
      logic [W-1:0] row_lane_reg;

      assign a_in = feed_a[gi*W +: W];
      assign b_in = feed_b[gi*W +: W];

      if (gi == 0) begin : g_direct
        always_ff @(posedge CLOCK) begin
          if (reset || abort_hit) begin
            col_lane_reg <= '0;
            row_lane_reg <= '0;
          end else if (advance) begin
            col_lane_reg <= a_in;
            row_lane_reg <= b_in;
          end
        end
      end else begin : g_chain
        // Lane gi sees its operand gi advances after lane 0.
        logic [W-1:0] a_chain_reg [gi];
        logic [W-1:0] b_chain_reg [gi];

        always_ff @(posedge CLOCK) begin
          if (reset || abort_hit) begin
            col_lane_reg <= '0;
            row_lane_reg <= '0;
            for (int d = 0; d < gi; d++) begin
              a_chain_reg[d] <= '0;
              b_chain_reg[d] <= '0;
            end
          end else if (advance) begin
            col_lane_reg   <= a_chain_reg[gi-1];
            row_lane_reg   <= b_chain_reg[gi-1];
            a_chain_reg[0] <= a_in;
            b_chain_reg[0] <= b_in;
            for (int d = 1; d < gi; d++) begin
              a_chain_reg[d] <= a_chain_reg[d-1];
              b_chain_reg[d] <= b_chain_reg[d-1];
            end
          end
        end
      end

      assign arr_col[gi*W +: W] = col_lane_reg;
      assign arr_row[gi*W +: W] = row_lane_reg;
    end
  endgenerate

endmodule
